// File: rtl/trees_pkg.sv
// Shared sizes and the loader state type for the trees accelerator host loader.
// The core dimensions live here so the loader, its counter and its interface always agree.
package trees_pkg;

    localparam int N_TREES        = 128;
    localparam int N_NODES        = 256;
    localparam int N_FEATURE      = 32;
    localparam int TREES_LEN_BITS = $clog2(N_NODES);
    localparam int TREE_IDX_BITS  = $clog2(N_TREES);
    localparam int FEAT_WORDS     = N_FEATURE / 2;
    localparam int FEAT_IDX_BITS  = $clog2(FEAT_WORDS);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        LD_TREES = 3'd1,
        LD_FEAT  = 3'd2,
        START    = 3'd3,
        WAIT     = 3'd4,
        RESULT   = 3'd5
    } loader_state_t;

endpackage

// File: rtl/trees_host_loader_if.sv
// Bundle of job control, input stream, core load/start/done and result signals.
// master is the loader's view; slave is the view of everything around it.
interface trees_host_loader_if;
    import trees_pkg::*;

    logic                      go;
    logic                      cfg_load_model;
    logic [TREE_IDX_BITS:0]    cfg_n_trees;
    logic                      busy;

    logic                      in_valid;
    logic                      in_ready;
    logic [63:0]               in_data;

    logic                      load_trees;
    logic [TREE_IDX_BITS-1:0]  n_tree;
    logic [TREES_LEN_BITS-1:0] n_node;
    logic [63:0]               tree_nodes;
    logic                      load_features;
    logic [31:0]               n_feature;
    logic [63:0]               features2;

    logic                      start;
    logic                      done;
    logic signed [31:0]        prediction;

    logic                      res_valid;
    logic                      res_ready;
    logic signed [31:0]        res_data;

    modport master (
        input  go, cfg_load_model, cfg_n_trees, in_valid, in_data,
               done, prediction, res_ready,
        output busy, in_ready, load_trees, n_tree, n_node, tree_nodes,
               load_features, n_feature, features2, start, res_valid, res_data
    );

    modport slave (
        output go, cfg_load_model, cfg_n_trees, in_valid, in_data,
               done, prediction, res_ready,
        input  busy, in_ready, load_trees, n_tree, n_node, tree_nodes,
               load_features, n_feature, features2, start, res_valid, res_data
    );

endinterface

// File: rtl/trees_idx_counter.sv
// Two-level index counter: inner index wraps at INNER_N and bumps the outer index.
// last flags the final beat, inner at its top with outer at outer_n-1.
module trees_idx_counter #(
    parameter int INNER_N = 256,
    parameter int OUTER_W = 7,
    parameter int INNER_W = $clog2(INNER_N)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clear,
    input  logic               step,
    input  logic [OUTER_W:0]   outer_n,
    output logic [INNER_W-1:0] inner_idx,
    output logic [OUTER_W-1:0] outer_idx,
    output logic               last
);

    logic inner_wrap;

    assign inner_wrap = (inner_idx == INNER_W'(INNER_N - 1));
    assign last       = inner_wrap && ({1'b0, outer_idx} == (outer_n - (OUTER_W + 1)'(1)));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            inner_idx <= '0;
            outer_idx <= '0;
        end else if (clear) begin
            inner_idx <= '0;
            outer_idx <= '0;
        end else if (step) begin
            if (inner_wrap) begin
                inner_idx <= '0;
                outer_idx <= outer_idx + 1'b1;
            end else begin
                inner_idx <= inner_idx + 1'b1;
            end
        end
    end

endmodule

// File: rtl/trees_host_loader.sv
// Streams tree nodes and feature pairs into the trees core, pulses start and
// returns the prediction captured on the first done rising edge after start.
module trees_host_loader
    import trees_pkg::*;
(
    input  logic clk,
    input  logic rst,
    trees_host_loader_if.master bus
);

    loader_state_t             state, state_nxt;
    logic [TREE_IDX_BITS:0]    cfg_n_q;
    logic                      start_arm;
    logic                      done_q;
    logic                      in_rdy;
    logic                      job_go;
    logic                      tree_step;
    logic                      feat_step;
    logic                      done_rise;
    logic                      tree_last;
    logic                      feat_last;
    logic [TREES_LEN_BITS-1:0] node_idx;
    logic [TREE_IDX_BITS-1:0]  tree_idx;
    logic [FEAT_IDX_BITS-1:0]  pair_idx;
    logic                      feat_outer_unused;

    function automatic logic [TREE_IDX_BITS:0] sat_trees(input logic [TREE_IDX_BITS:0] n);
        return (n > (TREE_IDX_BITS + 1)'(N_TREES)) ? (TREE_IDX_BITS + 1)'(N_TREES) : n;
    endfunction

    assign job_go    = (state == IDLE) && bus.go;
    assign tree_step = (state == LD_TREES) && bus.in_valid && in_rdy;
    assign feat_step = (state == LD_FEAT) && bus.in_valid && in_rdy;
    assign done_rise = bus.done && !done_q;

    trees_idx_counter #(
        .INNER_N (N_NODES),
        .OUTER_W (TREE_IDX_BITS)
    ) u_tree_cnt (
        .clk       (clk),
        .rst       (rst),
        .clear     (job_go),
        .step      (tree_step),
        .outer_n   (cfg_n_q),
        .inner_idx (node_idx),
        .outer_idx (tree_idx),
        .last      (tree_last)
    );

    // Feature phase is a single "tree" of FEAT_WORDS pair beats.
    trees_idx_counter #(
        .INNER_N (FEAT_WORDS),
        .OUTER_W (1)
    ) u_feat_cnt (
        .clk       (clk),
        .rst       (rst),
        .clear     (job_go),
        .step      (feat_step),
        .outer_n   (2'd1),
        .inner_idx (pair_idx),
        .outer_idx (feat_outer_unused),
        .last      (feat_last)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:     if (bus.go)
                          state_nxt = (bus.cfg_load_model && (bus.cfg_n_trees != '0)) ? LD_TREES : LD_FEAT;
            LD_TREES: if (tree_step && tree_last) state_nxt = LD_FEAT;
            LD_FEAT:  if (feat_step && feat_last) state_nxt = START;
            START:    if (start_arm) state_nxt = WAIT;
            WAIT:     if (done_rise) state_nxt = RESULT;
            RESULT:   if (bus.res_ready) state_nxt = IDLE;
            default:  state_nxt = IDLE;
        endcase
    end

    always_comb begin
        in_rdy        = (state == LD_TREES) || (state == LD_FEAT);
        bus.in_ready  = in_rdy;
        bus.start     = (state == START) && start_arm;
        bus.res_valid = (state == RESULT);
        bus.busy      = (state != IDLE);
    end

    // start_arm spends the first START cycle letting the final load strobe land.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cfg_n_q   <= '0;
            start_arm <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            done_q    <= bus.done;
            start_arm <= (state == START) && !start_arm;
            if (job_go) cfg_n_q <= sat_trees(bus.cfg_n_trees);
        end
    end

    // Accepted beat -> registered core write, one cycle later
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.load_trees    <= 1'b0;
            bus.load_features <= 1'b0;
            bus.n_tree        <= '0;
            bus.n_node        <= '0;
            bus.tree_nodes    <= '0;
            bus.n_feature     <= '0;
            bus.features2     <= '0;
            bus.res_data      <= '0;
        end else begin
            bus.load_trees    <= tree_step;
            bus.load_features <= feat_step;
            if (tree_step) begin
                bus.n_tree     <= tree_idx;
                bus.n_node     <= node_idx;
                bus.tree_nodes <= bus.in_data;
            end
            if (feat_step) begin
                bus.n_feature <= 32'({pair_idx, 1'b0});
                bus.features2 <= bus.in_data;
            end
            if ((state == WAIT) && done_rise) bus.res_data <= bus.prediction;
        end
    end

endmodule

// File: tb/tb_trees_host_loader.sv
// Bench for trees_host_loader: a job table with expected write counts and results,
// a queue-based model of the core write sequence, and a mid-job async reset sequence.
`timescale 1ns/1ps
module tb_trees_host_loader;
    import trees_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    trees_host_loader_if bus ();

    trees_host_loader dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        bit          is_tree;
        int          tree;
        int          node;
        int          feat;
        logic [63:0] data;
    } wr_t;

    typedef struct {
        int load;
        int ntrees;
        int vmode;
        int stale;
        int done_dly;
        int rdy_dly;
        int pred;
        int rand_pred;
        int go_hs;
        int exp_tree;
        int exp_feat;
        int exp_res;
    } job_t;

    wr_t         exp_q[$];
    logic [63:0] words_q[$];
    job_t        tbl[7];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    // The core should see every tree word in tree-major order, then the feature pairs.
    function automatic void build_model(input job_t j);
        int  nt;
        wr_t w;
        exp_q.delete();
        words_q.delete();
        nt = (j.load != 0) ? ((j.ntrees > N_TREES) ? N_TREES : j.ntrees) : 0;
        for (int t = 0; t < nt; t++) begin
            for (int n = 0; n < N_NODES; n++) begin
                w.is_tree = 1'b1; w.tree = t; w.node = n; w.feat = 0;
                w.data = {$urandom, $urandom};
                exp_q.push_back(w);
                words_q.push_back(w.data);
            end
        end
        for (int k = 0; k < N_FEATURE / 2; k++) begin
            w.is_tree = 1'b0; w.tree = 0; w.node = 0; w.feat = 2 * k;
            w.data = (k == 0) ? 64'h3F800000_40000000 : {$urandom, $urandom};
            exp_q.push_back(w);
            words_q.push_back(w.data);
        end
    endfunction

    task automatic run_job(input job_t j);
        int                 ntw;
        int                 nfw;
        int                 bound;
        bit                 seen_start;
        logic signed [31:0] pred;
        logic signed [31:0] exp_res;
        ntw = 0; nfw = 0; seen_start = 0;
        build_model(j);
        bound   = words_q.size() * 4 + 200;
        pred    = (j.rand_pred != 0) ? $urandom : j.pred;
        exp_res = (j.rand_pred != 0) ? pred : j.exp_res;

        @(posedge clk); #1;
        bus.done           = (j.stale != 0);
        bus.res_ready      = 1'b0;
        bus.cfg_load_model = (j.load != 0);
        bus.cfg_n_trees    = (TREE_IDX_BITS + 1)'(j.ntrees);
        bus.go             = 1'b1;
        @(posedge clk); #1;
        bus.go             = 1'b0;
        bus.cfg_load_model = (j.load == 0);
        bus.cfg_n_trees    = '1;

        fork
            begin : drv
                int idx;
                int dc;
                bit v;
                bit acc;
                idx = 0; dc = 0;
                while (idx < words_q.size() && dc < bound) begin
                    case (j.vmode)
                        0:       v = 1'b1;
                        1:       v = (dc % 2 == 0);
                        default: v = ($urandom_range(0, 1) == 1);
                    endcase
                    bus.in_valid = v;
                    bus.in_data  = v ? words_q[idx] : 64'hDEAD_BEEF_DEAD_BEEF;
                    @(negedge clk);
                    acc = bus.in_valid && bus.in_ready;
                    @(posedge clk); #1;
                    if (acc) idx++;
                    dc++;
                end
                bus.in_valid = 1'b1;
                bus.in_data  = 64'hBAD0_BAD0_BAD0_BAD0;
            end
            begin : mon
                bit  pend;
                bit  stb;
                int  mc;
                int  last_stb;
                wr_t e;
                pend = 0; mc = 0; last_stb = -100;
                while (!seen_start && mc < bound) begin
                    @(negedge clk);
                    mc++;
                    if (mc == 1) chk("busy_after_go", bus.busy, 1);
                    stb = bus.load_trees | bus.load_features;
                    chk("strobe_timing", stb, pend);
                    chk("strobe_exclusive", bus.load_trees & bus.load_features, 0);
                    if (bus.load_trees) ntw++;
                    if (bus.load_features) nfw++;
                    if (stb) begin
                        last_stb = mc;
                        if (exp_q.size() == 0) begin
                            chk("extra_write", stb, 0);
                        end else begin
                            e = exp_q.pop_front();
                            chk("write_kind", bus.load_trees, e.is_tree);
                            if (e.is_tree) begin
                                chk("n_tree", bus.n_tree, e.tree);
                                chk("n_node", bus.n_node, e.node);
                                chk("tree_nodes", bus.tree_nodes, e.data);
                            end else begin
                                chk("n_feature", bus.n_feature, e.feat);
                                chk("features2", bus.features2, e.data);
                            end
                        end
                    end
                    if (bus.start) begin
                        seen_start = 1;
                        chk("start_gap", mc - last_stb, 1);
                        chk("writes_left", exp_q.size(), 0);
                    end
                    pend = bus.in_valid && bus.in_ready;
                end
                if (!seen_start) chk("start_timeout", seen_start, 1);
            end
        join

        chk("tree_writes", ntw, j.exp_tree);
        chk("feat_writes", nfw, j.exp_feat);
        @(negedge clk);
        chk("start_single", bus.start, 0);

        for (int c = 0; c < j.done_dly; c++) begin
            @(posedge clk); #1;
            bus.go = (c % 2 == 0);
            @(negedge clk);
            chk("no_early_result", bus.res_valid, 0);
            chk("quiet_wait", bus.load_trees | bus.load_features, 0);
        end
        if (j.stale != 0) begin
            @(posedge clk); #1;
            bus.go   = 1'b0;
            bus.done = 1'b0;
            repeat (2) begin
                @(negedge clk);
                chk("no_result_on_fall", bus.res_valid, 0);
            end
        end
        @(posedge clk); #1;
        bus.go         = 1'b0;
        bus.prediction = pred;
        bus.done       = 1'b1;
        @(posedge clk); #1;
        bus.prediction = ~pred;
        @(negedge clk);
        chk("res_valid_latency", bus.res_valid, 1);
        chk("res_data", bus.res_data, exp_res);

        for (int c = 0; c < j.rdy_dly; c++) begin
            @(posedge clk); #1;
            bus.go = (c % 2 == 0);
            @(negedge clk);
            chk("res_hold_valid", bus.res_valid, 1);
            chk("res_hold_data", bus.res_data, exp_res);
            chk("busy_hold", bus.busy, 1);
            chk("no_write_in_result", bus.load_trees | bus.load_features, 0);
        end
        @(posedge clk); #1;
        bus.go        = (j.go_hs != 0);
        bus.res_ready = 1'b1;
        @(posedge clk); #1;
        bus.go        = 1'b0;
        bus.res_ready = 1'b0;
        @(negedge clk);
        chk("res_valid_cleared", bus.res_valid, 0);
        chk("busy_cleared", bus.busy, 0);
        @(negedge clk);
        chk("go_at_handshake_ignored", bus.busy, 0);
        bus.in_valid = 1'b0;
    endtask

    initial begin
        #3ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit found;
        //           load ntr vm stl ddly rdly pred          rp hs  trees  ft  res
        tbl[0] = '{1, 2,   0, 0,  20,  0,   -7,           0, 0,  512,   16, -7};
        tbl[1] = '{0, 2,   0, 0,  5,   1,   123,          0, 0,  0,     16, 123};
        tbl[2] = '{1, 1,   1, 0,  3,   2,   -300,         0, 0,  256,   16, -300};
        tbl[3] = '{0, 0,   2, 1,  4,   5,   -1000,        0, 1,  0,     16, -1000};
        tbl[4] = '{1, 0,   0, 0,  2,   0,   5,            0, 0,  0,     16, 5};
        tbl[5] = '{1, 200, 0, 0,  1,   3,   32'h7FFFFFFF, 0, 1,  32768, 16, 32'h7FFFFFFF};
        tbl[6] = '{1, 3,   2, 1,  6,   2,   0,            1, 0,  768,   16, 0};

        bus.go = 1'b0; bus.cfg_load_model = 1'b0; bus.cfg_n_trees = '0;
        bus.in_valid = 1'b0; bus.in_data = '0;
        bus.done = 1'b0; bus.prediction = '0; bus.res_ready = 1'b0;
        rst = 1'b1;
        #22;
        chk("rst_busy", bus.busy, 0);
        chk("rst_in_ready", bus.in_ready, 0);
        chk("rst_load_trees", bus.load_trees, 0);
        chk("rst_load_features", bus.load_features, 0);
        chk("rst_start", bus.start, 0);
        chk("rst_res_valid", bus.res_valid, 0);
        chk("rst_n_tree", bus.n_tree, 0);
        chk("rst_n_node", bus.n_node, 0);
        chk("rst_n_feature", bus.n_feature, 0);
        chk("rst_tree_nodes", bus.tree_nodes, 0);
        chk("rst_features2", bus.features2, 0);
        chk("rst_res_data", bus.res_data, 0);
        @(posedge clk); #1;
        rst = 1'b0;

        for (int t = 0; t < 7; t++) run_job(tbl[t]);

        // Async reset in the middle of the tree phase, then a clean job from index 0.
        @(posedge clk); #1;
        bus.done = 1'b0; bus.cfg_load_model = 1'b1;
        bus.cfg_n_trees = (TREE_IDX_BITS + 1)'(2);
        bus.go = 1'b1;
        @(posedge clk); #1;
        bus.go = 1'b0;
        bus.in_valid = 1'b1;
        found = 0;
        for (int c = 0; c < 600 && !found; c++) begin
            bus.in_data = {$urandom, $urandom};
            @(negedge clk);
            if (bus.load_trees && bus.n_tree == 1 && bus.n_node == 40) found = 1;
            else begin
                @(posedge clk); #1;
            end
        end
        chk("midjob_reached", found, 1);
        #1 rst = 1'b1;
        #1;
        chk("arst_load_trees", bus.load_trees, 0);
        chk("arst_busy", bus.busy, 0);
        chk("arst_in_ready", bus.in_ready, 0);
        chk("arst_n_tree", bus.n_tree, 0);
        chk("arst_n_node", bus.n_node, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        bus.in_valid = 1'b0;
        run_job(tbl[0]);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/trees_host_loader.md
Name: trees_host_loader

Overview:
- Initiator side of the trees accelerator load/start/done interface.
- Consumes a 64-bit valid/ready word stream from host memory or a DMA. Drives the accelerator's tree-node write port, then its feature write port.
- Pulses start, waits for done, and returns the signed prediction on a valid/ready result port.
- Sits between the SoC data mover and the trees core. Replaces hand-driven bench loading.

Parameters:
- N_TREES, 128, number of trees in the core
- N_NODES, 256, nodes+leaves per tree (one 64-bit word each)
- N_FEATURE, 32, 32-bit float features per sample; must be even
- TREES_LEN_BITS, $clog2(N_NODES), node index width
- TREE_IDX_BITS, $clog2(N_TREES), tree index width

Ports:
- clk  in  1  single clock
- rst  in  1  asynchronous, active-high reset
- go  in  1  one-cycle request to run one job; ignored while busy=1
- cfg_load_model  in  1  1: tree phase before features; 0: reuse loaded model
- cfg_n_trees  in  TREE_IDX_BITS+1  trees to load (0..N_TREES); latched on go
- busy  out  1  high from accepted go until result handshake completes
- in_valid  in  1  stream word valid
- in_ready  out  1  loader accepts word
- in_data  in  64  tree node word, or feature pair {f[2k+1], f[2k]}
- load_trees  out  1  tree-node write strobe to core
- n_tree  out  TREE_IDX_BITS  tree index
- n_node  out  TREES_LEN_BITS  node index
- tree_nodes  out  64  node word
- load_features  out  1  feature write strobe to core
- n_feature  out  32  even feature index (2*k)
- features2  out  64  feature pair
- start  out  1  one-cycle start pulse to core
- done  in  1  core completion flag (level; may be stale high)
- prediction  in  32  signed core result
- res_valid  out  1  result valid
- res_ready  in  1  result consumer ready
- res_data  out  32  captured signed prediction

Behaviour:
- Reset (async, any state): FSM to IDLE. busy, in_ready, load_trees, load_features, start and res_valid are 0. Indices, tree_nodes, features2 and res_data are 0.
- FSM states: IDLE, LD_TREES, LD_FEAT, START, WAIT, RESULT.
- IDLE:
  - go latches cfg_* and sets busy.
  - Next state is LD_TREES if cfg_load_model=1 and cfg_n_trees!=0, else LD_FEAT.
  - cfg_n_trees>N_TREES is clamped to N_TREES.
- in_ready=1 only in LD_TREES and LD_FEAT. A beat is accepted when in_valid&in_ready.
- Registered write, 1-cycle latency:
  - The cycle after acceptance, the load strobe is high for exactly one cycle.
  - Index and data are held stable until the next accepted beat.
  - Back-to-back beats give a continuous strobe with incrementing index.
- LD_TREES:
  - Node counter j counts 0..N_NODES-1; at wrap, tree counter i increments.
  - On the beat with i=cfg_n_trees-1 and j=N_NODES-1, go to LD_FEAT.
  - Word order is tree-major: n_tree=i, n_node=j.
- LD_FEAT:
  - Pair counter k counts 0..N_FEATURE/2-1, with n_feature=2*k.
  - After the last beat, go to START.
  - Words beyond the job are not consumed; in_ready=0.
- START:
  - Waits one cycle so the last load strobe lands, then asserts start for exactly one cycle and goes to WAIT.
  - Capture done_q=done in the start cycle.
- WAIT:
  - Completion is a done rising edge (done & ~done_q, done_q registered each cycle). A level left high from a previous job is never accepted.
  - On completion, res_data<=prediction and go to RESULT.
- RESULT:
  - res_valid=1, res_data stable until res_ready.
  - The handshake cycle clears res_valid and busy and returns to IDLE.
  - go in that same cycle is ignored; it is accepted from the following cycle.
- in_valid low mid-phase: counters and outputs hold; no timeout.
- Counters reset to 0 at every job start.

Decomposition:
- Package trees_pkg:
  - N_TREES, N_NODES, N_FEATURE defaults
  - derived widths
  - FEAT_WORDS=N_FEATURE/2
  - state enum loader_state_t
- Sub-module trees_idx_counter: a nested two-level counter (inner wrap at N_NODES, outer terminal at cfg_n_trees) with a last flag. It is reused for the feature phase with outer fixed at 1.

Test Plan:
- cfg_load_model=1, cfg_n_trees=2, 512+16 words streamed with in_valid always 1 -> exactly 512 load_trees pulses (last n_tree=1, n_node=255), then 16 load_features pulses (n_feature 0..30), then one start. Stub core done rising 20 cycles later with prediction=-7 -> res_data=-7.
- cfg_load_model=0 -> no load_trees pulse; 16 feature writes, then start. Feature word 0x3F800000_40000000 appears on features2 with n_feature=0.
- in_valid toggling 1/0 each cycle -> strobes only the cycle after accepted beats; index sequence unbroken; total counts as above.
- done held high from a previous job at start -> no completion until done falls and rises again; res_valid stays 0 meanwhile.
- res_ready low for 5 cycles -> res_valid and res_data stable; go pulses during busy are ignored, with no extra load strobes.
- rst asserted mid LD_TREES (n_tree=1, n_node=40) -> all strobes and busy drop asynchronously. A new job after release restarts at n_tree=0, n_node=0.
